// File: rtl/multiword_add_sequencer_if.sv
// Handshake bundle for the word-serial wide adder: control, operand stream and sum stream.
interface multiword_add_sequencer_if;
  logic        start;
  logic        cin;
  logic [31:0] a_word;
  logic [31:0] b_word;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] sum_word;
  logic        sum_valid;
  logic        sum_last;
  logic        out_ready;
  logic        cout;
  logic        busy;
  logic        done;

  modport master (
    output start, cin, a_word, b_word, in_valid, out_ready,
    input  in_ready, sum_word, sum_valid, sum_last, cout, busy, done
  );

  modport slave (
    input  start, cin, a_word, b_word, in_valid, out_ready,
    output in_ready, sum_word, sum_valid, sum_last, cout, busy, done
  );
endinterface

// File: rtl/multiword_add_sequencer.sv
// Word-serial (32*NUM_WORDS)-bit adder: one word pair per beat, LSW first, carry chained
// between beats through a registered carry and a carry-select 32-bit adder stage.
module carry_select_adder_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);
  logic [8:0] c;

  assign c[0] = cin;

  // Each 4-bit block precomputes both carry-in cases; the ripple only goes through muxes.
  for (genvar g = 0; g < 8; g++) begin : g_blk
    logic [4:0] s0;
    logic [4:0] s1;
    assign s0 = {1'b0, a[4*g +: 4]} + {1'b0, b[4*g +: 4]};
    assign s1 = {1'b0, a[4*g +: 4]} + {1'b0, b[4*g +: 4]} + 5'd1;
    assign sum[4*g +: 4] = c[g] ? s1[3:0] : s0[3:0];
    assign c[g+1]        = c[g] ? s1[4]   : s0[4];
  end

  assign cout = c[8];
endmodule

module multiword_add_sequencer #(
  parameter int NUM_WORDS = 4,
  parameter int IDX_W     = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  multiword_add_sequencer_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              carry_q, carry_d;
  logic [31:0]       sum_word_q, sum_word_d;
  logic              sum_valid_q, sum_valid_d;
  logic              sum_last_q, sum_last_d;
  logic              cout_q, cout_d;
  logic              done_q, done_d;
  logic              in_ready_c;
  logic              accept;
  logic [31:0]       add_sum;
  logic              add_cout;

  carry_select_adder_32bit u_add (
    .a    (bus.a_word),
    .b    (bus.b_word),
    .cin  (carry_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    sum_word_d  = sum_word_q;
    sum_valid_d = sum_valid_q;
    sum_last_d  = sum_last_q;
    cout_d      = cout_q;
    done_d      = 1'b0;
    in_ready_c  = 1'b0;
    accept      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          carry_d = bus.cin;
          idx_d   = '0;
          cout_d  = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Single output register: it may refill in the same cycle it is drained.
        in_ready_c = ~sum_valid_q | bus.out_ready;
        accept     = in_ready_c & bus.in_valid;
        if (accept) begin
          sum_word_d  = add_sum;
          sum_valid_d = 1'b1;
          sum_last_d  = (idx_q == LAST_IDX);
          carry_d     = add_cout;
          if (idx_q == LAST_IDX) begin
            cout_d  = add_cout;
            idx_d   = '0;
            state_d = DRAIN;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else if (sum_valid_q & bus.out_ready) begin
          sum_valid_d = 1'b0;
          sum_last_d  = 1'b0;
        end
      end
      DRAIN: begin
        if (sum_valid_q & bus.out_ready) begin
          sum_valid_d = 1'b0;
          sum_last_d  = 1'b0;
          done_d      = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      sum_word_q  <= '0;
      sum_valid_q <= 1'b0;
      sum_last_q  <= 1'b0;
      cout_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      sum_word_q  <= sum_word_d;
      sum_valid_q <= sum_valid_d;
      sum_last_q  <= sum_last_d;
      cout_q      <= cout_d;
      done_q      <= done_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.sum_word  = sum_word_q;
  assign bus.sum_valid = sum_valid_q;
  assign bus.sum_last  = sum_last_q;
  assign bus.cout      = cout_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Randomized bench for multiword_add_sequencer against a whole-number wide-add reference.
module tb_multiword_add_sequencer;
  localparam int NW = 4;
  localparam int W  = 32 * NW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multiword_add_sequencer_if bus ();

  multiword_add_sequencer #(.NUM_WORDS(NW), .IDX_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // mode: 0 = out_ready high, 1 = random valid/ready, 2 = 3-cycle stall after first sum
  // Called and returns at posedge+1.
  task automatic run_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                         input int mode, input bit misuse, input int abort_beats);
    logic [W:0]  full;
    logic [31:0] prev_word;
    logic        prev_last;
    bit          prev_stall;
    bit          done_seen;
    int          w, got, stall, cyc;

    full       = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    w          = 0;
    got        = 0;
    cyc        = 0;
    stall      = (mode == 2) ? 3 : 0;
    prev_stall = 1'b0;
    done_seen  = 1'b0;
    prev_word  = '0;
    prev_last  = 1'b0;

    bus.start    = 1'b1;
    bus.cin      = ci;
    bus.in_valid = 1'b1;
    bus.a_word   = $urandom;
    bus.b_word   = $urandom;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check_eq("busy_after_start", bus.busy, 1);
    check_eq("cout_cleared", bus.cout, 0);

    while (!done_seen && cyc < 300) begin
      if (abort_beats > 0 && w == abort_beats) begin
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("abort_sum_valid", bus.sum_valid, 0);
        check_eq("abort_busy", bus.busy, 0);
        check_eq("abort_cout", bus.cout, 0);
        check_eq("abort_done", bus.done, 0);
        @(posedge clk); #1;
        return;
      end
      if (w < NW) begin
        bus.a_word = a[32*w +: 32];
        bus.b_word = b[32*w +: 32];
      end else begin
        bus.a_word = $urandom;
        bus.b_word = $urandom;
      end
      bus.in_valid  = (mode == 1) ? ($urandom_range(3) != 0) : 1'b1;
      bus.out_ready = 1'b1;
      if (mode == 1) bus.out_ready = ($urandom_range(2) != 0);
      if (mode == 2 && got >= 1 && stall > 0) begin
        bus.out_ready = 1'b0;
        stall--;
      end
      bus.start = (misuse && w < NW) ? 1'($urandom_range(1)) : 1'b0;
      bus.cin   = misuse ? ~ci : ci;

      @(negedge clk);
      check_eq("sum_valid", bus.sum_valid, (w > got));
      check_eq("in_ready", bus.in_ready, (w < NW) && (!bus.sum_valid || bus.out_ready));
      if (prev_stall) begin
        check_eq("hold_valid", bus.sum_valid, 1);
        check_eq("hold_word", bus.sum_word, prev_word);
        check_eq("hold_last", bus.sum_last, prev_last);
      end
      if (bus.sum_valid && bus.out_ready && got < NW) begin
        check_eq("sum_word", bus.sum_word, full[32*got +: 32]);
        check_eq("sum_last", bus.sum_last, (got == NW - 1));
        got++;
      end
      prev_stall = bus.sum_valid && !bus.out_ready;
      prev_word  = bus.sum_word;
      prev_last  = bus.sum_last;
      if (bus.done) begin
        done_seen = 1'b1;
        check_eq("done_after_all", got, NW);
        check_eq("cout", bus.cout, full[W]);
        check_eq("idle_after_done", bus.busy, 0);
      end
      if (bus.in_valid && bus.in_ready) w++;
      cyc++;
      @(posedge clk); #1;
    end

    check_eq("done_seen", done_seen, 1);
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    @(negedge clk);
    check_eq("done_pulse", bus.done, 0);
    check_eq("cout_held", bus.cout, full[W]);
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra, rb;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.cin       = 1'b0;
    bus.a_word    = '0;
    bus.b_word    = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_sum_word", bus.sum_word, 0);
    check_eq("rst_sum_valid", bus.sum_valid, 0);
    check_eq("rst_sum_last", bus.sum_last, 0);
    check_eq("rst_cout", bus.cout, 0);
    check_eq("rst_done", bus.done, 0);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_in_ready", bus.in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Operand words while idle must be ignored.
    bus.in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_eq("idle_in_ready", bus.in_ready, 0);
      check_eq("idle_sum_valid", bus.sum_valid, 0);
      check_eq("idle_busy", bus.busy, 0);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;

    run_add({4{32'hFFFFFFFF}}, '0, 1'b1, 0, 1'b0, 0);
    run_add({32'h80000000, 32'h00000000, 32'h89ABCDEF, 32'h12345678},
            {32'h80000000, 32'h00000000, 32'h01234567, 32'h87654321}, 1'b0, 0, 1'b0, 0);
    run_add({96'h0, 32'hFFFFFFFF}, {96'h0, 32'h00000001}, 1'b0, 0, 1'b0, 0);
    ra = {$urandom, $urandom, $urandom, $urandom};
    rb = {$urandom, $urandom, $urandom, $urandom};
    run_add(ra, rb, 1'b1, 2, 1'b0, 0);
    ra = {$urandom, 32'hFFFFFFFF, $urandom, $urandom};
    rb = {$urandom, $urandom, $urandom, $urandom};
    run_add(ra, rb, 1'b0, 1, 1'b1, 0);
    run_add(ra, rb, 1'b1, 0, 1'b0, 2);
    run_add({4{32'hFFFFFFFF}}, {4{32'hFFFFFFFF}}, 1'b0, 0, 1'b0, 0);

    for (int i = 0; i < 20; i++) begin
      ra = {$urandom, $urandom, $urandom, $urandom};
      rb = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(3) == 0) ra[63:32] = ~rb[63:32];
      run_add(ra, rb, 1'($urandom_range(1)), int'($urandom_range(2)),
              bit'($urandom_range(1)), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
